t05_sram_arbiter: RTL and testbench
===================================

// Module: t05_sram_arbiter
// PURPOSE
// - Single-port SRAM arbiter/sequencer for the team_05 compression pipeline.
// - Shares one 32-bit SRAM port among five requesters:
//   HIST(0), FLV(1), HTREE(2), CODEBOOK(3), TRANSLATION(4).
// - Adds each client's region base to its local address and runs one read/write at a time.
// - Returns ack + read data to the owner. Sits between the stage modules and the SRAM/wishbone interface.
// PARAMETERS
// - NUM_CLIENTS  5    number of requesters; client i owns region base i<<ADDR_W
// - ADDR_W       8    client-local word address width
// - DATA_W       32   data width
// - TIMEOUT_CYC  255  WAIT-state cycle limit (used only with T05_SRAM_ARB_TIMEOUT_EN)
// PORTS
// - clk          in   1                    clock, rising edge
// - rst          in   1                    asynchronous reset, active-high
// - req_i        in   NUM_CLIENTS          per-client request; held until ack_o[i]
// - we_i         in   NUM_CLIENTS          per-client write(1)/read(0)
// - addr_i       in   NUM_CLIENTS*ADDR_W   packed local addresses; client i = [i*ADDR_W +: ADDR_W]
// - wdata_i      in   NUM_CLIENTS*DATA_W   packed write data
// - gnt_o        out  NUM_CLIENTS          one-hot, 1-cycle pulse when a request is latched
// - ack_o        out  NUM_CLIENTS          one-hot, 1-cycle pulse when the access completes
// - rdata_o      out  DATA_W               read data; valid during the ack cycle of a read
// - err_o        out  1                    timeout flag, pulses with ack_o
// - busy_o       out  1                    high whenever state != IDLE
// - mem_req_o    out  1                    1-cycle access strobe to SRAM
// - mem_we_o     out  1                    write enable, qualified by mem_req_o
// - mem_addr_o   out  32                   absolute word address
// - mem_wdata_o  out  DATA_W               write data
// - mem_busy_i   in   1                    SRAM busy; access is complete when it is low in WAIT
// - mem_rdata_i  in   DATA_W               SRAM read data, valid when mem_busy_i is low in WAIT
// BEHAVIOUR
// - Reset: all outputs 0, state=IDLE, rr_last=NUM_CLIENTS-1 (client 0 has first priority).
// - FSM IDLE->ISSUE->WAIT->RESP->IDLE:
//   - IDLE: if req_i!=0, pick the first requester after rr_last (round-robin, wraps).
//     Latch id, we, addr, wdata. Pulse gnt_o[id]. Set rr_last=id. Go to ISSUE.
//   - ISSUE: mem_req_o=1 for exactly 1 cycle. mem_we_o=we.
//     mem_addr_o = (id<<ADDR_W) | addr, zero-extended to 32 bits.
//     mem_wdata_o = latched wdata. Go to WAIT.
//   - WAIT: stay while mem_busy_i=1. When mem_busy_i=0: capture mem_rdata_i if read, go to RESP.
//   - RESP: ack_o[id]=1 and rdata_o driven. Go to IDLE.
// - Latency: gnt at cycle T, ack at T+3+N, where N = WAIT cycles with mem_busy_i=1.
// - req_i is sampled only in IDLE. Requests arriving while busy wait their turn.
// - Dropping req before ack does not cancel a latched access.
// - A requester that keeps req high in the cycle after ack is treated as a new request and re-arbitrated.
// - rdata_o holds the last read value until the next read ack; writes do not change it.
// - mem_addr_o/mem_we_o/mem_wdata_o hold the latched values from ISSUE through RESP, and 0 in IDLE.
// - Only the latched client's addr/wdata slice is used; other slices are ignored.
// - Reset mid-operation (any state): outputs clear immediately and no ack is issued.
//   The aborted client must re-request.
// CONFIGURATION
// - T05_SRAM_ARB_TIMEOUT_EN defined:
//   - An 8..16-bit WAIT counter clears on ISSUE.
//   - If mem_busy_i stays 1 for TIMEOUT_CYC consecutive WAIT cycles, go to RESP with
//     ack_o[id]=1, err_o=1, rdata_o=32'hDEAD_BEEF for that cycle.
// - Not defined: no counter, err_o tied 0, WAIT lasts until mem_busy_i=0.
// TESTING
// - HIST write, addr 0x05, data 0x11, mem_busy_i=0 -> gnt_o=00001 @T; @T+1 mem_req_o=1,
//   mem_we_o=1, mem_addr_o=0x005; ack_o=00001 @T+3.
// - FLV read, addr 0x10, mem_busy_i=1 for 4 WAIT cycles, mem_rdata_i=0xCAFE0001
//   -> mem_addr_o=0x110; ack_o=00010 @T+7; rdata_o=0xCAFE0001.
// - All five req_i high after reset, each dropped at its ack -> grants in order 0,1,2,3,4;
//   exactly one ack each; never two grants overlap.
// - Client 2 holds req continuously, client 3 also requesting -> grants alternate 2,3,2,3.
// - rst asserted during WAIT -> mem_req_o/ack_o/busy_o=0 immediately; after release,
//   requests from clients 0 and 4 -> client 0 granted first.
// - Macro on, TIMEOUT_CYC=8, mem_busy_i stuck at 1 -> ack+err_o on the cycle after the
//   8th WAIT cycle, rdata_o=0xDEADBEEF. Macro off -> no ack, busy_o stays 1.

Source files
------------

// File: rtl/t05_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_CLIENTS requesters.
// Optional WAIT-state timeout is enabled by defining T05_SRAM_ARB_TIMEOUT_EN.
module t05_sram_arbiter #(
  parameter int NUM_CLIENTS = 5,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        req_i,
  input  logic [NUM_CLIENTS-1:0]        we_i,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] addr_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wdata_i,
  output logic [NUM_CLIENTS-1:0]        gnt_o,
  output logic [NUM_CLIENTS-1:0]        ack_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          err_o,
  output logic                          busy_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [31:0]                   mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic                          mem_busy_i,
  input  logic [DATA_W-1:0]             mem_rdata_i
);

  localparam int ID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [ID_W-1:0]        rr_last_r;
  logic [ID_W-1:0]        id_r;
  logic [ID_W-1:0]        pick_id_s;
  logic [ID_W-1:0]        cand_s;
  logic                   pick_found_s;
  logic                   timeout_hit_s;
  logic [ADDR_W-1:0]      addr_arr_s  [NUM_CLIENTS];
  logic [DATA_W-1:0]      wdata_arr_s [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] ack_r;
  logic                   busy_r;
  logic                   mem_req_r;
  logic                   mem_we_r;
  logic [31:0]            mem_addr_r;
  logic [DATA_W-1:0]      mem_wdata_r;
  logic [DATA_W-1:0]      rdata_r;

  genvar g;
  generate
    for (g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
      assign addr_arr_s[g]  = addr_i[g*ADDR_W +: ADDR_W];
      assign wdata_arr_s[g] = wdata_i[g*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin pick: first requester after the last granted client, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = {ID_W{1'b0}};
    cand_s       = {ID_W{1'b0}};
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand_s = ID_W'((int'(rr_last_r) + k) % NUM_CLIENTS);
      if (!pick_found_s && req_i[cand_s]) begin
        pick_found_s = 1'b1;
        pick_id_s    = cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

`ifdef T05_SRAM_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC < 256) ? 8 : 16;

  logic [TO_W-1:0] wait_cnt_r;
  logic            err_r;

  assign timeout_hit_s = (wait_cnt_r == TO_W'(TIMEOUT_CYC - 1));

  // Consecutive busy WAIT cycles; err marks a RESP entered by timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= {TO_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      if (state_r == ST_ISSUE) begin
        wait_cnt_r <= {TO_W{1'b0}};
      end else if ((state_r == ST_WAIT) && mem_busy_i) begin
        wait_cnt_r <= wait_cnt_r + TO_W'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      err_r <= (state_r == ST_WAIT) && mem_busy_i && timeout_hit_s;
    end
  end

  assign err_o = err_r;
`else
  assign timeout_hit_s = 1'b0;
  assign err_o         = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (!mem_busy_i || timeout_hit_s) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Request latch, SRAM port and response registers; strobes decode next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_r   <= ID_W'(NUM_CLIENTS - 1);
      id_r        <= {ID_W{1'b0}};
      ack_r       <= {NUM_CLIENTS{1'b0}};
      busy_r      <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
    end else begin
      busy_r    <= (state_next_s != ST_IDLE);
      mem_req_r <= (state_next_s == ST_ISSUE);
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            id_r        <= pick_id_s;
            rr_last_r   <= pick_id_s;
            mem_we_r    <= we_i[pick_id_s];
            mem_addr_r  <= 32'({pick_id_s, addr_arr_s[pick_id_s]});
            mem_wdata_r <= wdata_arr_s[pick_id_s];
          end else begin
            mem_we_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (state_next_s == ST_RESP) begin
            ack_r <= NUM_CLIENTS'(1'b1) << id_r;
            if (mem_busy_i) begin
              rdata_r <= DATA_W'(32'hDEAD_BEEF);
            end else if (!mem_we_r) begin
              rdata_r <= mem_rdata_i;
            end else begin
              rdata_r <= rdata_r;
            end
          end else begin
            ack_r <= {NUM_CLIENTS{1'b0}};
          end
        end
        ST_RESP: begin
          ack_r       <= {NUM_CLIENTS{1'b0}};
          mem_we_r    <= 1'b0;
          mem_addr_r  <= 32'h0000_0000;
          mem_wdata_r <= {DATA_W{1'b0}};
        end
        default: begin
          ack_r <= {NUM_CLIENTS{1'b0}};
        end
      endcase
    end
  end

  assign gnt_o       = (!rst && (state_r == ST_IDLE) && pick_found_s) ?
                       (NUM_CLIENTS'(1'b1) << pick_id_s) : {NUM_CLIENTS{1'b0}};
  assign ack_o       = ack_r;
  assign rdata_o     = rdata_r;
  assign busy_o      = busy_r;
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Directed self-checking bench for t05_sram_arbiter (timeout case follows T05_SRAM_ARB_TIMEOUT_EN).
module tb_t05_sram_arbiter;

  localparam int NC = 5;
  localparam int AW = 8;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    req_i, we_i;
  logic [NC*AW-1:0] addr_i;
  logic [NC*DW-1:0] wdata_i;
  logic [NC-1:0]    gnt_o, ack_o;
  logic [DW-1:0]    rdata_o;
  logic             err_o, busy_o, mem_req_o, mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [DW-1:0]    mem_wdata_o;
  logic             mem_busy_i;
  logic [DW-1:0]    mem_rdata_i;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   n_g, overlap, last_id;
  int   order_q [8];
  int   ack_cnt [NC];
  logic [AW-1:0] loc_addr [NC];
  bit   done_f;

  t05_sram_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_busy_i(mem_busy_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Step to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req_i       = '0;
    we_i        = '0;
    addr_i      = '0;
    wdata_i     = '0;
    mem_busy_i  = 1'b0;
    mem_rdata_i = '0;
  endtask

  task automatic set_client(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_i[c]            = 1'b1;
    we_i[c]             = we;
    addr_i[c*AW +: AW]  = a;
    wdata_i[c*DW +: DW] = d;
    loc_addr[c]         = a;
  endtask

  // Runs until all requests are gone and the arbiter is idle, logging grants/acks.
  task automatic collect(input bit drop_at_ack, input int want, input int budget);
    logic [31:0] ea;
    n_g     = 0;
    overlap = 0;
    last_id = 0;
    done_f  = 1'b0;
    for (int i = 0; i < NC; i++) ack_cnt[i] = 0;
    for (int k = 0; k < budget && !done_f; k++) begin
      #1;
      if ($countones(gnt_o) > 1 || (gnt_o != '0 && busy_o)) overlap++;
      for (int i = 0; i < NC; i++) begin
        if (gnt_o[i]) begin
          if (n_g < 8) order_q[n_g] = i;
          n_g++;
          last_id = i;
        end
        if (ack_o[i]) ack_cnt[i]++;
      end
      if (mem_req_o) begin
        ea = (32'(last_id) << AW) | 32'(loc_addr[last_id]);
        check_val("rr_mem_addr", mem_addr_o, ea);
      end
      if (ack_o != '0) begin
        if (drop_at_ack) req_i = req_i & ~ack_o;
        else if (n_g >= want) req_i = '0;
      end
      if (req_i == '0 && !busy_o) done_f = 1'b1;
      else cyc();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_gnt", gnt_o, 0);
    check_val("rst_ack", ack_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_mem_req", mem_req_o, 0);
    check_val("rst_mem_addr", mem_addr_o, 0);
    check_val("rst_rdata", rdata_o, 0);
    check_val("rst_err", err_o, 0);
    rst = 1'b0;
    cyc();

    // HIST write, no SRAM wait
    set_client(0, 1'b1, 8'h05, 32'h0000_0011);
    #1;
    check_val("t1_gnt", gnt_o, 5'b00001);
    cyc();
    check_val("t1_mem_req", mem_req_o, 1);
    check_val("t1_mem_we", mem_we_o, 1);
    check_val("t1_mem_addr", mem_addr_o, 32'h0000_0005);
    check_val("t1_mem_wdata", mem_wdata_o, 32'h0000_0011);
    check_val("t1_gnt_off", gnt_o, 0);
    check_val("t1_busy", busy_o, 1);
    cyc();
    check_val("t1_mem_req_pulse", mem_req_o, 0);
    check_val("t1_ack_early", ack_o, 0);
    cyc();
    check_val("t1_ack", ack_o, 5'b00001);
    check_val("t1_err", err_o, 0);
    check_val("t1_rdata_write", rdata_o, 0);
    req_i[0] = 1'b0;
    cyc();
    check_val("t1_idle_busy", busy_o, 0);
    check_val("t1_idle_addr", mem_addr_o, 0);
    check_val("t1_idle_ack", ack_o, 0);

    // FLV read with 4 busy WAIT cycles
    set_client(1, 1'b0, 8'h10, 32'hFFFF_FFFF);
    mem_busy_i = 1'b1;
    #1;
    check_val("t2_gnt", gnt_o, 5'b00010);
    cyc();
    check_val("t2_mem_addr", mem_addr_o, 32'h0000_0110);
    check_val("t2_mem_we", mem_we_o, 0);
    check_val("t2_mem_req", mem_req_o, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_val("t2_wait_ack", ack_o, 0);
      check_val("t2_wait_busy", busy_o, 1);
    end
    cyc();
    mem_busy_i  = 1'b0;
    mem_rdata_i = 32'hCAFE_0001;
    check_val("t2_ack_early", ack_o, 0);
    cyc();
    check_val("t2_ack", ack_o, 5'b00010);
    check_val("t2_rdata", rdata_o, 32'hCAFE_0001);
    req_i[1]    = 1'b0;
    mem_rdata_i = 32'h1234_5678;
    cyc();
    check_val("t2_rdata_hold", rdata_o, 32'hCAFE_0001);
    check_val("t2_idle", busy_o, 0);

    // All five request after reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle_inputs();
    cyc();
    for (int c = 0; c < NC; c++) set_client(c, 1'b0, 8'(c * 16 + 3), 32'h0);
    collect(1'b1, NC, 100);
    check_val("t3_done", done_f, 1);
    check_val("t3_ngrants", n_g, NC);
    check_val("t3_overlap", overlap, 0);
    for (int c = 0; c < NC; c++) begin
      check_val("t3_order", order_q[c], c);
      check_val("t3_ack_once", ack_cnt[c], 1);
    end

    // Clients 2 and 3 both hold requests: alternation
    set_client(2, 1'b0, 8'h21, 32'h0);
    set_client(3, 1'b1, 8'h31, 32'h5);
    collect(1'b0, 4, 60);
    check_val("t4_done", done_f, 1);
    check_val("t4_ngrants", n_g, 4);
    check_val("t4_g0", order_q[0], 2);
    check_val("t4_g1", order_q[1], 3);
    check_val("t4_g2", order_q[2], 2);
    check_val("t4_g3", order_q[3], 3);
    check_val("t4_overlap", overlap, 0);

    // Reset during WAIT aborts the access
    idle_inputs();
    set_client(1, 1'b0, 8'h22, 32'h0);
    mem_busy_i = 1'b1;
    #1;
    check_val("t5_gnt", gnt_o, 5'b00010);
    cyc();
    cyc();
    check_val("t5_busy_pre", busy_o, 1);
    check_val("t5_addr_pre", mem_addr_o, 32'h0000_0122);
    rst = 1'b1;
    #1;
    check_val("t5_rst_busy", busy_o, 0);
    check_val("t5_rst_mem_req", mem_req_o, 0);
    check_val("t5_rst_ack", ack_o, 0);
    check_val("t5_rst_addr", mem_addr_o, 0);
    check_val("t5_rst_gnt", gnt_o, 0);
    req_i[1]   = 1'b0;
    mem_busy_i = 1'b0;
    cyc();
    rst = 1'b0;
    set_client(0, 1'b0, 8'h01, 32'h0);
    set_client(4, 1'b0, 8'h44, 32'h0);
    collect(1'b1, 2, 40);
    check_val("t5_done", done_f, 1);
    check_val("t5_first", order_q[0], 0);
    check_val("t5_second", order_q[1], 4);
    check_val("t5_no_ack1", ack_cnt[1], 0);
    check_val("t5_ack4", ack_cnt[4], 1);

    // SRAM stuck busy
    idle_inputs();
    set_client(3, 1'b0, 8'h33, 32'h0);
    mem_busy_i = 1'b1;
    #1;
    check_val("t6_gnt", gnt_o, 5'b01000);
    cyc();
`ifdef T05_SRAM_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      cyc();
      check_val("t6_wait_ack", ack_o, 0);
    end
    cyc();
    check_val("t6_to_ack", ack_o, 5'b01000);
    check_val("t6_to_err", err_o, 1);
    check_val("t6_to_rdata", rdata_o, 32'hDEAD_BEEF);
    req_i[3] = 1'b0;
    cyc();
    check_val("t6_err_pulse", err_o, 0);
    check_val("t6_idle", busy_o, 0);
`else
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_val("t6_stuck_ack", ack_o, 0);
      check_val("t6_stuck_busy", busy_o, 1);
    end
    check_val("t6_err", err_o, 0);
    mem_busy_i  = 1'b0;
    mem_rdata_i = 32'h0BAD_F00D;
    cyc();
    check_val("t6_ack", ack_o, 5'b01000);
    check_val("t6_rdata", rdata_o, 32'h0BAD_F00D);
    req_i[3] = 1'b0;
    cyc();
    check_val("t6_idle", busy_o, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
